// File: rtl/rvseed_pkg.sv
// Shared RV32I encodings, ALU operation set and ALU evaluation for the rvseed core.
package rvseed_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_REG    = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } alu_op_e;

   function automatic logic [XLEN-1:0] alu_exec(input alu_op_e op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_XOR:  r = a ^ b;
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = $signed(a) >>> b[4:0];
         ALU_SLT:  r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: r = {{(XLEN-1){1'b0}}, a < b};
         default:  r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/rvseed_core_inst_mem.sv
// Instruction memory: combinational word read. Contents come from an external
// loader (file-based memory load or hierarchical preload) and are never touched by reset.
module inst_mem
  import rvseed_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [XLEN-1:0]   data_o
);

  logic [XLEN-1:0] mem_data [0:DEPTH-1];

  assign data_o = mem_data[addr_i];

endmodule

// File: rtl/rvseed_core.sv
// Single-cycle RV32I core with inline decoder, ALU, register file and data memory.
// Optional macro RVSEED_REGFILE_RESET_EN adds asynchronous clearing of x1..x31.
module rvseed_core
   import rvseed_pkg::*;
#(
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024
) (
   input logic clk,
   input logic rst_n,
   input logic enable
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic [XLEN-1:0] regs_q [0:31];
   logic [XLEN-1:0] dmem_q [0:DMEM_DEPTH-1];
   logic [XLEN-1:0] instr;

   inst_mem #(.DEPTH(IMEM_DEPTH), .ADDR_W(IAW)) U_INST_MEM (
      .addr_i (pc_q[IAW+1:2]),
      .data_o (instr)
   );

   logic [6:0] opcode, funct7;
   logic [4:0] rd, rs1, rs2;
   logic [2:0] funct3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] rs1_v, rs2_v, ld_addr, st_addr, ld_word, ld_shift, ld_data;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];
   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_v    = (rs1 == 5'd0) ? '0 : regs_q[rs1];
   assign rs2_v    = (rs2 == 5'd0) ? '0 : regs_q[rs2];
   assign pc_plus4 = pc_q + 32'd4;
   assign ld_addr  = rs1_v + imm_i;
   assign st_addr  = rs1_v + imm_s;

   // Misaligned loads read the aligned word; the low address bits pick the lanes.
   assign ld_word  = dmem_q[DAW'(ld_addr >> 2)];
   assign ld_shift = ld_word >> {ld_addr[1:0], 3'b000};

   always_comb begin
      ld_data = '0;
      case (funct3)
         F3_LB:   ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         F3_LH:   ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         F3_LW:   ld_data = ld_word;
         F3_LBU:  ld_data = {24'b0, ld_shift[7:0]};
         F3_LHU:  ld_data = {16'b0, ld_shift[15:0]};
         default: ld_data = '0;
      endcase
   end

   alu_op_e alu_op;
   logic    alu_legal, br_taken, is_reg;

   assign is_reg = (opcode == OPC_REG);

   always_comb begin
      alu_op    = ALU_ADD;
      alu_legal = 1'b1;
      case (funct3)
         F3_ADD_SUB: begin
            alu_op    = (is_reg && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            alu_legal = !is_reg || funct7 == F7_BASE || funct7 == F7_ALT;
         end
         F3_SLL: begin
            alu_op    = ALU_SLL;
            alu_legal = (funct7 == F7_BASE);
         end
         F3_SR: begin
            alu_op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            alu_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
         end
         F3_SLT:  alu_op = ALU_SLT;
         F3_SLTU: alu_op = ALU_SLTU;
         F3_XOR:  alu_op = ALU_XOR;
         F3_OR:   alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
      // Register-register forms other than ADD/SUB/SRL/SRA admit only funct7 = 0.
      if (is_reg && funct3 != F3_ADD_SUB && funct3 != F3_SR && funct7 != F7_BASE)
         alu_legal = 1'b0;
   end

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = (rs1_v == rs2_v);
         F3_BNE:  br_taken = (rs1_v != rs2_v);
         F3_BLT:  br_taken = ($signed(rs1_v) < $signed(rs2_v));
         F3_BGE:  br_taken = ($signed(rs1_v) >= $signed(rs2_v));
         F3_BLTU: br_taken = (rs1_v < rs2_v);
         F3_BGEU: br_taken = (rs1_v >= rs2_v);
         default: br_taken = 1'b0;
      endcase
   end

   logic            rd_we, mem_we, wr_ok;
   logic [XLEN-1:0] rd_wdata, mem_wdata;
   logic [3:0]      mem_be;

   always_comb begin
      pc_d      = pc_plus4;
      rd_we     = 1'b0;
      rd_wdata  = '0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      case (opcode)
         OPC_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
         OPC_AUIPC: begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
         OPC_JAL: begin
            rd_we    = 1'b1;
            rd_wdata = pc_plus4;
            pc_d     = pc_q + imm_j;
         end
         OPC_JALR: if (funct3 == 3'b000) begin
            rd_we    = 1'b1;
            rd_wdata = pc_plus4;
            pc_d     = (rs1_v + imm_i) & ~32'd1;
         end
         OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
         OPC_LOAD: if (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
            rd_we    = 1'b1;
            rd_wdata = ld_data;
         end
         OPC_STORE: begin
            mem_we = 1'b1;
            case (funct3)
               F3_SB: begin mem_be = 4'b0001 << st_addr[1:0]; mem_wdata = {4{rs2_v[7:0]}}; end
               F3_SH: begin mem_be = st_addr[1] ? 4'b1100 : 4'b0011; mem_wdata = {2{rs2_v[15:0]}}; end
               F3_SW: begin mem_be = 4'b1111; mem_wdata = rs2_v; end
               default: mem_we = 1'b0;
            endcase
         end
         OPC_IMM, OPC_REG: if (alu_legal) begin
            rd_we    = 1'b1;
            rd_wdata = alu_exec(alu_op, rs1_v, is_reg ? rs2_v : imm_i);
         end
         default: ;
      endcase
   end

   // Reset and enable both gate every architectural write.
   assign wr_ok = enable && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      pc_q <= '0;
      else if (enable) pc_q <= pc_d;
   end

`ifdef RVSEED_REGFILE_RESET_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      end else if (wr_ok && rd_we && rd != 5'd0) begin
         regs_q[rd] <= rd_wdata;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (wr_ok && rd_we && rd != 5'd0) regs_q[rd] <= rd_wdata;
   end
`endif

   always_ff @(posedge clk) begin
      if (wr_ok && mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_be[b]) dmem_q[DAW'(st_addr >> 2)][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
   end

endmodule

// File: tb/tb_rvseed_core.sv
// Self-checking bench for rvseed_core: programs are preloaded into the instruction
// memory during reset and architectural state is inspected hierarchically.
module tb_rvseed_core;

   localparam int OP_IMM = 'h13, OP_REG = 'h33, OP_LOAD = 'h03, OP_JALR = 'h67;
   localparam int OP_LUI = 'h37, OP_AUIPC = 'h17;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n;
   logic enable;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   int          reg_q[$];
   logic [31:0] prog[$];

   rvseed_core dut (.clk(clk), .rst_n(rst_n), .enable(enable));

   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                         input logic [31:0] f3, input logic [31:0] rd,
                                         input logic [31:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3,
                                         input logic [31:0] rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd,
                                         input logic [31:0] op);
      return {imm[31:12], rd[4:0], op[6:0]};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction

   // Holds the core in reset, loads prog (rest of memory = NOP), releases on a falling edge.
   task automatic load_prog();
      rst_n  = 1'b0;
      enable = 1'b0;
      for (int i = 0; i < 1024; i++)
         dut.U_INST_MEM.mem_data[i] = (i < prog.size()) ? prog[i] : NOP;
      prog.delete();
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_reg(input int r, input logic [31:0] v);
      reg_q.push_back(r);
      exp_q.push_back(v);
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      rst_n  = 1'b1;
      enable = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (dut.pc_q !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", dut.pc_q, 32'h0); end

      prog.push_back(enc_i(9, 0, 0, 1, OP_IMM));
      load_prog();
      exp_q.push_back(32'd20);
      run(5);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL pre_pulse_pc got=%h exp=%h", dut.pc_q, exp); end

      // Pulse reset in the high phase, well away from any falling or rising edge.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (dut.pc_q !== 32'h0) begin bad++; $display("FAIL async_reset_pc got=%h exp=%h", dut.pc_q, 32'h0); end

      dut.U_INST_MEM.mem_data[0] = enc_i('h55, 0, 0, 1, OP_IMM);
      enable = 1'b1;
      run(3);
      exp_q.push_back(32'h0);
`ifdef RVSEED_REGFILE_RESET_EN
      exp_q.push_back(32'h0);
`else
      exp_q.push_back(32'd9);
`endif
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL held_reset_pc got=%h exp=%h", dut.pc_q, exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[1] !== exp) begin bad++; $display("FAIL held_reset_x1 got=%h exp=%h", dut.regs_q[1], exp); end

      rst_n = 1'b1;
      exp_q.push_back(32'd4);
      exp_q.push_back(32'h55);
      run(1);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL first_fetch_pc got=%h exp=%h", dut.pc_q, exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[1] !== exp) begin bad++; $display("FAIL first_fetch_x1 got=%h exp=%h", dut.regs_q[1], exp); end
   endtask

   task automatic test_add();
      logic [31:0] exp;
      int r;
      prog.push_back(enc_i(5, 0, 0, 1, OP_IMM));
      prog.push_back(enc_i(-3, 0, 0, 2, OP_IMM));
      prog.push_back(enc_r(0, 2, 1, 0, 3));
      expect_reg(1, 32'd5);
      expect_reg(2, 32'hFFFF_FFFD);
      expect_reg(3, 32'd2);
      load_prog();
      run(3);
      while (exp_q.size() > 0) begin
         r = reg_q.pop_front(); exp = exp_q.pop_front(); total++;
         if (dut.regs_q[r] !== exp) begin bad++; $display("FAIL add_x%0d got=%h exp=%h", r, dut.regs_q[r], exp); end
      end
      total++;
      if (dut.pc_q !== 32'd12) begin bad++; $display("FAIL add_pc got=%h exp=%h", dut.pc_q, 32'd12); end
   endtask

   task automatic test_alu();
      logic [31:0] exp;
      int r;
      prog.push_back(enc_i(-1, 0, 0, 1, OP_IMM));
      prog.push_back(enc_i(1, 0, 0, 2, OP_IMM));
      prog.push_back(enc_r('h20, 1, 2, 0, 3));     expect_reg(3, 32'd2);
      prog.push_back(enc_r(0, 2, 1, 4, 4));        expect_reg(4, 32'hFFFF_FFFE);
      prog.push_back(enc_r('h20, 2, 1, 5, 5));     expect_reg(5, 32'hFFFF_FFFF);
      prog.push_back(enc_r(0, 2, 1, 5, 6));        expect_reg(6, 32'h7FFF_FFFF);
      prog.push_back(enc_r(0, 2, 1, 2, 7));        expect_reg(7, 32'd1);
      prog.push_back(enc_r(0, 2, 1, 3, 8));        expect_reg(8, 32'd0);
      prog.push_back(enc_i(31, 2, 1, 9, OP_IMM));  expect_reg(9, 32'h8000_0000);
      prog.push_back(enc_i('h404, 9, 5, 10, OP_IMM)); expect_reg(10, 32'hF800_0000);
      prog.push_back(32'h0000_000F);
      prog.push_back(32'h0000_0073);
      prog.push_back(32'h0000_01FF);
      prog.push_back(enc_i(-1, 2, 3, 11, OP_IMM));  expect_reg(11, 32'd1);
      prog.push_back(enc_i(5, 0, 0, 0, OP_IMM));
      prog.push_back(enc_r(0, 0, 0, 0, 12));       expect_reg(12, 32'd0);
      prog.push_back(enc_r(0, 6, 4, 7, 13));       expect_reg(13, 32'h7FFF_FFFE);
      prog.push_back(enc_i('hF, 9, 6, 14, OP_IMM)); expect_reg(14, 32'h8000_000F);
      prog.push_back(enc_i('hF0, 1, 7, 15, OP_IMM)); expect_reg(15, 32'h0000_00F0);
      prog.push_back(enc_i(0, 1, 2, 16, OP_IMM));   expect_reg(16, 32'd1);
      prog.push_back(enc_i(-1, 2, 4, 17, OP_IMM));  expect_reg(17, 32'hFFFF_FFFE);
      prog.push_back(enc_r(0, 4, 2, 1, 18));       expect_reg(18, 32'h4000_0000);
      load_prog();
      run(22);
      while (exp_q.size() > 0) begin
         r = reg_q.pop_front(); exp = exp_q.pop_front(); total++;
         if (dut.regs_q[r] !== exp) begin bad++; $display("FAIL alu_x%0d got=%h exp=%h", r, dut.regs_q[r], exp); end
      end
      total++;
      if (dut.pc_q !== 32'd88) begin bad++; $display("FAIL alu_pc got=%h exp=%h", dut.pc_q, 32'd88); end
   endtask

   task automatic test_load_store();
      logic [31:0] exp;
      int r;
      prog.push_back(enc_u(32'h8000_0000, 1, OP_LUI));
      prog.push_back(enc_i('hFF, 1, 0, 1, OP_IMM));
      prog.push_back(enc_s(0, 1, 0, 2));
      prog.push_back(enc_i(0, 0, 0, 4, OP_LOAD));  expect_reg(4, 32'hFFFF_FFFF);
      prog.push_back(enc_i(0, 0, 4, 5, OP_LOAD));  expect_reg(5, 32'h0000_00FF);
      prog.push_back(enc_i(0, 0, 2, 7, OP_LOAD));  expect_reg(7, 32'h8000_00FF);
      prog.push_back(enc_i(3, 0, 0, 9, OP_LOAD));  expect_reg(9, 32'hFFFF_FF80);
      prog.push_back(enc_i(2, 0, 5, 10, OP_LOAD)); expect_reg(10, 32'h0000_8000);
      prog.push_back(enc_i(2, 0, 1, 11, OP_LOAD)); expect_reg(11, 32'hFFFF_8000);
      prog.push_back(enc_s(5, 1, 0, 0));
      prog.push_back(enc_i(5, 0, 4, 8, OP_LOAD));  expect_reg(8, 32'h0000_00FF);
      prog.push_back(enc_s(6, 1, 0, 1));
      prog.push_back(enc_i(6, 0, 5, 6, OP_LOAD));  expect_reg(6, 32'h0000_00FF);
      load_prog();
      run(13);
      while (exp_q.size() > 0) begin
         r = reg_q.pop_front(); exp = exp_q.pop_front(); total++;
         if (dut.regs_q[r] !== exp) begin bad++; $display("FAIL ldst_x%0d got=%h exp=%h", r, dut.regs_q[r], exp); end
      end
      total++;
      if (dut.dmem_q[0] !== 32'h8000_00FF) begin
         bad++; $display("FAIL sw_word got=%h exp=%h", dut.dmem_q[0], 32'h8000_00FF);
      end
   endtask

   task automatic test_branch();
      logic [31:0] exp;
      prog.push_back(enc_i(-1, 0, 0, 1, OP_IMM));
      prog.push_back(enc_i(1, 0, 0, 2, OP_IMM));
      prog.push_back(enc_i(0, 0, 0, 3, OP_IMM));
      prog.push_back(enc_b(8, 2, 1, 4));
      prog.push_back(enc_i(1, 0, 0, 3, OP_IMM));
      prog.push_back(enc_b(8, 2, 1, 6));
      prog.push_back(enc_i(7, 0, 0, 4, OP_IMM));
      load_prog();
      exp_q.push_back(32'd20);
      run(4);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL blt_taken_pc got=%h exp=%h", dut.pc_q, exp); end
      exp_q.push_back(32'd24);
      run(1);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL bltu_not_taken_pc got=%h exp=%h", dut.pc_q, exp); end
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd7);
      run(1);
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[3] !== exp) begin bad++; $display("FAIL branch_skip_x3 got=%h exp=%h", dut.regs_q[3], exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[4] !== exp) begin bad++; $display("FAIL branch_fall_x4 got=%h exp=%h", dut.regs_q[4], exp); end
   endtask

   task automatic test_jump();
      logic [31:0] exp;
      repeat (4) prog.push_back(NOP);
      prog.push_back(enc_j(8, 1));
      prog.push_back(enc_u(32'h0000_1000, 2, OP_AUIPC));
      prog.push_back(enc_i(3, 1, 0, 0, OP_JALR));
      load_prog();
      exp_q.push_back(32'h18);
      exp_q.push_back(32'h14);
      run(5);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL jal_pc got=%h exp=%h", dut.pc_q, exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[1] !== exp) begin bad++; $display("FAIL jal_link got=%h exp=%h", dut.regs_q[1], exp); end
      exp_q.push_back(32'h16);
      run(1);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL jalr_pc got=%h exp=%h", dut.pc_q, exp); end
      exp_q.push_back(32'h1A);
      exp_q.push_back(32'h1016);
      run(1);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL auipc_pc got=%h exp=%h", dut.pc_q, exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[2] !== exp) begin bad++; $display("FAIL auipc_x2 got=%h exp=%h", dut.regs_q[2], exp); end
   endtask

   task automatic test_enable();
      logic [31:0] exp;
      prog.push_back(enc_i(0, 0, 0, 3, OP_IMM));
      prog.push_back(enc_i(5, 0, 0, 1, OP_IMM));
      prog.push_back(enc_i(-3, 0, 0, 2, OP_IMM));
      prog.push_back(enc_r(0, 2, 1, 0, 3));
      prog.push_back(enc_i(10, 3, 0, 3, OP_IMM));
      prog.push_back(enc_s(8, 3, 0, 2));
      load_prog();
      run(3);
      enable = 1'b0;
      exp_q.push_back(32'd12);
      exp_q.push_back(32'd0);
      run(5);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL frozen_pc got=%h exp=%h", dut.pc_q, exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[3] !== exp) begin bad++; $display("FAIL frozen_x3 got=%h exp=%h", dut.regs_q[3], exp); end
      enable = 1'b1;
      exp_q.push_back(32'd24);
      exp_q.push_back(32'd12);
      exp_q.push_back(32'd12);
      run(3);
      exp = exp_q.pop_front(); total++;
      if (dut.pc_q !== exp) begin bad++; $display("FAIL resume_pc got=%h exp=%h", dut.pc_q, exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.regs_q[3] !== exp) begin bad++; $display("FAIL resume_x3 got=%h exp=%h", dut.regs_q[3], exp); end
      exp = exp_q.pop_front(); total++;
      if (dut.dmem_q[2] !== exp) begin bad++; $display("FAIL resume_store got=%h exp=%h", dut.dmem_q[2], exp); end
   endtask

   task automatic test_random_addi();
      logic [31:0] vals[1:8];
      logic [31:0] imm, exp;
      int r;
      for (int k = 1; k <= 8; k++) begin
         imm     = 32'($urandom_range(0, 4095));
         vals[k] = {{20{imm[11]}}, imm[11:0]};
         prog.push_back(enc_i(imm, 0, 0, k, OP_IMM));
         expect_reg(k, vals[k]);
      end
      prog.push_back(enc_r(0, 2, 1, 0, 20));      expect_reg(20, vals[1] + vals[2]);
      prog.push_back(enc_r('h20, 4, 3, 0, 21));   expect_reg(21, vals[3] - vals[4]);
      prog.push_back(enc_r(0, 6, 5, 4, 22));      expect_reg(22, vals[5] ^ vals[6]);
      prog.push_back(enc_r(0, 8, 7, 3, 23));      expect_reg(23, {31'b0, vals[7] < vals[8]});
      load_prog();
      run(12);
      while (exp_q.size() > 0) begin
         r = reg_q.pop_front(); exp = exp_q.pop_front(); total++;
         if (dut.regs_q[r] !== exp) begin bad++; $display("FAIL rand_x%0d got=%h exp=%h", r, dut.regs_q[r], exp); end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_alu();
      test_load_store();
      test_branch();
      test_jump();
      test_enable();
      test_random_addi();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
